seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for the 8-digit 7-segment display. Holds a 32-bit

---
 rtl/seg_scan_ctrl.sv | 82 ++++++++
 tb/tb_seg_scan_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 8-digit 7-segment scan sequencer; words commit only at frame wrap (SEG_LZB_EN adds leading-zero blanking).
// Latency: O_I/O_blank follow O_S combinationally; an accepted word is visible within 8*DIV+1 cycles.
// Backpressure: O_ready is low during reset and while a word is pending; the pending slot frees at frame wrap.
module seg_scan_ctrl #(
   parameter int DIV   = 1000,
   parameter int N_DIG = 8
) (
   input  logic        I_clk,
   input  logic        I_rst,
   input  logic [31:0] I_data,
   input  logic        I_valid,
   output logic        O_ready,
   input  logic [7:0]  I_en,
   output logic [3:0]  O_I,
   output logic [2:0]  O_S,
   output logic        O_blank,
   output logic        O_frame
);
   localparam int CW = $clog2(DIV) + 1;

   logic [CW-1:0] div_cnt;
   logic [2:0]    idx;
   logic [31:0]   active;
   logic [31:0]   pending;
   logic          pend_full;
   logic          frame_q;
   logic          tick;
   logic          wrap;
   logic          accept;

   assign tick    = (div_cnt == CW'(DIV - 1));
   assign wrap    = tick && (idx == 3'(N_DIG - 1));
   assign O_ready = ~pend_full & ~I_rst;
   assign accept  = I_valid & O_ready;

   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         div_cnt   <= '0;
         idx       <= '0;
         active    <= '0;
         pending   <= '0;
         pend_full <= 1'b0;
         frame_q   <= 1'b0;
      end else begin
         frame_q <= wrap;
         if (tick) begin
            div_cnt <= '0;
            idx     <= idx + 3'd1;
         end else begin
            div_cnt <= div_cnt + CW'(1);
         end
         // A wrap with a full slot never coincides with an accept (O_ready is low),
         // so a word accepted on a wrap edge waits for the following wrap.
         if (wrap && pend_full) begin
            active    <= pending;
            pend_full <= 1'b0;
         end else if (accept) begin
            pending   <= I_data;
            pend_full <= 1'b1;
         end
      end
   end

   assign O_S     = idx;
   assign O_I     = active[{idx, 2'b00} +: 4];
   assign O_frame = frame_q;

`ifdef SEG_LZB_EN
   // lz[k]: nibbles k..7 of the displayed word are all zero; digit 0 always shows.
   logic [7:0] lz;
   always_comb begin
      lz = '0;
      for (int k = 1; k < 8; k++) begin
         lz[k] = ((active >> (4 * k)) == 32'd0);
      end
   end
   assign O_blank = ~I_en[idx] | lz[idx];
`else
   assign O_blank = ~I_en[idx];
`endif

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (DIV=4): per-cycle reference model plus table and corner-case sequences.
module tb_seg_scan_ctrl;
   localparam int DIV = 4;
   localparam int FRAME = 8 * DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] data = '0;
   logic        valid = 1'b0;
   logic [7:0]  en = 8'hFF;
   logic        ready;
   logic [3:0]  oi;
   logic [2:0]  os;
   logic        blank;
   logic        frame;

   seg_scan_ctrl #(.DIV(DIV), .N_DIG(8)) dut (
      .I_clk(clk), .I_rst(rst), .I_data(data), .I_valid(valid), .O_ready(ready),
      .I_en(en), .O_I(oi), .O_S(os), .O_blank(blank), .O_frame(frame)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: time since reset determines the scan position; words move
   // from a one-entry slot to the display at every multiple of FRAME cycles.
   int unsigned t = 0;
   logic [31:0] m_act = '0;
   logic [31:0] m_pend = '0;
   logic        m_pv = 1'b0;
   logic        m_frame = 1'b0;
   logic        last_acc = 1'b0;

   typedef struct {
      logic [31:0] word;
      logic [7:0]  en;
      logic [7:0]  blank;
   } vec_t;
   vec_t vecs[4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0d)", nm, act, exp, t);
      end
   endtask

   task automatic timeout(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting", nm);
   endtask

   task automatic model_check();
      int unsigned s;
      logic [31:0] sh;
      logic        b;
      s  = (t / DIV) % 8;
      sh = m_act >> (4 * s);
      b  = ~en[s];
`ifdef SEG_LZB_EN
      if (s != 0 && sh == 32'd0) b = 1'b1;
`endif
      chk("model_S", {29'd0, os}, s);
      chk("model_I", {28'd0, oi}, sh & 32'hF);
      chk("model_blank", {31'd0, blank}, {31'd0, b});
      chk("model_frame", {31'd0, frame}, {31'd0, m_frame});
      chk("model_ready", {31'd0, ready}, {31'd0, (!m_pv && !rst)});
   endtask

   task automatic tick();
      logic acc;
      @(posedge clk);
      last_acc = 1'b0;
      if (rst) begin
         t = 0; m_act = '0; m_pv = 1'b0;
      end else begin
         acc = valid && !m_pv;
         t++;
         if ((t % FRAME) == 0 && m_pv) begin
            m_act = m_pend; m_pv = 1'b0;
         end else if (acc) begin
            m_pend = data; m_pv = 1'b1; last_acc = 1'b1;
         end
      end
      m_frame = !rst && ((t % FRAME) == 0);
      #1;
      model_check();
   endtask

   task automatic load_word(input string nm, input logic [31:0] w);
      int n;
      data = w; valid = 1'b1; n = 0;
      do begin tick(); n++; end while (!last_acc && n < 200);
      if (!last_acc) timeout(nm);
      valid = 1'b0;
   endtask

   task automatic wait_frame(input string nm);
      int n;
      n = 0;
      do begin tick(); n++; end while (frame !== 1'b1 && n < 100);
      if (frame !== 1'b1) timeout(nm);
   endtask

   initial begin
      logic [31:0] w;
      int n;
      int nz;

      vecs[0] = '{32'h87654321, 8'hFF, 8'h00};
      vecs[1] = '{32'hFFFFFFFF, 8'h0F, 8'hF0};
`ifdef SEG_LZB_EN
      vecs[2] = '{32'h00000A05, 8'hFF, 8'hF8};
      vecs[3] = '{32'h00000000, 8'hFF, 8'hFE};
`else
      vecs[2] = '{32'h00000A05, 8'hFF, 8'h00};
      vecs[3] = '{32'h00000000, 8'hFF, 8'h00};
`endif

      // Reset held three cycles.
      repeat (3) tick();
      chk("rst_S", {29'd0, os}, 0);
      chk("rst_I", {28'd0, oi}, 0);
      chk("rst_frame", {31'd0, frame}, 0);
      chk("rst_ready", {31'd0, ready}, 0);
      rst = 1'b0;
      tick();
      chk("ready_after_rst", {31'd0, ready}, 1);

      // Table: each word shown for one whole frame starting at digit 0.
      for (int r = 0; r < 4; r++) begin
         en = vecs[r].en;
         load_word("tbl_accept", vecs[r].word);
         wait_frame("tbl_frame");
         w = vecs[r].word;
         for (int k = 0; k < 8; k++) begin
            chk("tbl_S", {29'd0, os}, k);
            chk("tbl_I", {28'd0, oi}, {28'd0, w[4*k +: 4]});
            chk("tbl_blank", {31'd0, blank}, {31'd0, vecs[r].blank[k]});
            repeat (DIV) tick();
         end
      end
      en = 8'hFF;

      // Two words in one frame: second is held off until the first commits.
      load_word("ones_accept", 32'h11111111);
      chk("ready_held", {31'd0, ready}, 0);
      load_word("twos_accept", 32'h22222222);
      chk("twos_accept_S", {29'd0, os}, 0);
      chk("ones_shown", {28'd0, oi}, 1);
      wait_frame("twos_frame");
      chk("twos_shown", {28'd0, oi}, 2);

      // Reset mid-frame with a pending word: the pending word is dropped.
      load_word("dead_accept", 32'hDEADBEEF);
      n = 0;
      do begin tick(); n++; end while (os !== 3'd5 && n < 100);
      if (os !== 3'd5) timeout("reach_S5");
      chk("pend_full_S5", {31'd0, ready}, 0);
      rst = 1'b1;
      tick();
      chk("midrst_S", {29'd0, os}, 0);
      chk("midrst_I", {28'd0, oi}, 0);
      chk("midrst_ready", {31'd0, ready}, 0);
      rst = 1'b0;
      tick();
      chk("midrst_ready_after", {31'd0, ready}, 1);
      nz = 0;
      repeat (2 * FRAME) begin
         tick();
         if (oi != 4'd0) nz++;
      end
      chk("old_pending_dropped", nz, 0);

      // Random traffic, enables and occasional resets against the model.
      for (int i = 0; i < 1500; i++) begin
         valid = ($urandom_range(0, 3) == 0);
         data  = $urandom;
         if ($urandom_range(0, 15) == 0) en = 8'($urandom);
         rst   = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst = 1'b0;
      valid = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
